// File: rtl/data_memory_arbiter.sv
// Two-port arbiter sharing the single-port data_memory between the core LSU (port 0)
// and the DMA/debug port (port 1); one access per two-cycle slot.
//
// state | meaning
// IDLE  | waiting for a request; ready follows the combinational grant
// SERVE | memory access in flight for owner_q; response issued on the closing edge
module data_memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_0_i,
    input  logic              req_write_0_i,
    input  logic [ADDR_W-1:0] req_addr_0_i,
    input  logic [DATA_W-1:0] req_wdata_0_i,
    input  logic              req_valid_1_i,
    input  logic              req_write_1_i,
    input  logic [ADDR_W-1:0] req_addr_1_i,
    input  logic [DATA_W-1:0] req_wdata_1_i,
    output logic              req_ready_0_o,
    output logic              req_ready_1_o,
    output logic              resp_valid_0_o,
    output logic              resp_valid_1_o,
    output logic [DATA_W-1:0] resp_rdata_0_o,
    output logic [DATA_W-1:0] resp_rdata_1_o,
    output logic              mem_read_enable_o,
    output logic              mem_write_enable_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_0_q, resp_valid_0_d;
    logic              resp_valid_1_q, resp_valid_1_d;
    logic [DATA_W-1:0] resp_rdata_0_q, resp_rdata_0_d;
    logic [DATA_W-1:0] resp_rdata_1_q, resp_rdata_1_d;

    logic              grant_0, grant_1;
    logic              ready_0, ready_1;
    logic [DATA_W-1:0] resp_data;

    // Port 0 takes a tie when fixed priority is on or port 1 was served last.
    always_comb begin
        grant_0 = req_valid_0_i & (~req_valid_1_i | FIXED_PRIO | last_grant_q);
        grant_1 = req_valid_1_i & ~grant_0;
        ready_0 = (state_q == IDLE) & grant_0;
        ready_1 = (state_q == IDLE) & grant_1;
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        mem_re_d       = mem_re_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        resp_valid_0_d = 1'b0;
        resp_valid_1_d = 1'b0;
        resp_rdata_0_d = resp_rdata_0_q;
        resp_rdata_1_d = resp_rdata_1_q;
        resp_data      = mem_we_q ? '0 : mem_read_data_i;

        case (state_q)
            IDLE: begin
                if (ready_1) begin
                    state_d      = SERVE;
                    last_grant_d = 1'b1;
                    owner_d      = 1'b1;
                    mem_re_d     = ~req_write_1_i;
                    mem_we_d     = req_write_1_i;
                    mem_addr_d   = req_addr_1_i;
                    mem_wdata_d  = req_wdata_1_i;
                end else if (ready_0) begin
                    state_d      = SERVE;
                    last_grant_d = 1'b0;
                    owner_d      = 1'b0;
                    mem_re_d     = ~req_write_0_i;
                    mem_we_d     = req_write_0_i;
                    mem_addr_d   = req_addr_0_i;
                    mem_wdata_d  = req_wdata_0_i;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_re_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (owner_q) begin
                    resp_valid_1_d = 1'b1;
                    resp_rdata_1_d = resp_data;
                end else begin
                    resp_valid_0_d = 1'b1;
                    resp_rdata_0_d = resp_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            mem_re_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            resp_valid_0_q <= 1'b0;
            resp_valid_1_q <= 1'b0;
            resp_rdata_0_q <= '0;
            resp_rdata_1_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            mem_re_q       <= mem_re_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            resp_valid_0_q <= resp_valid_0_d;
            resp_valid_1_q <= resp_valid_1_d;
            resp_rdata_0_q <= resp_rdata_0_d;
            resp_rdata_1_q <= resp_rdata_1_d;
        end
    end

    assign req_ready_0_o      = ready_0;
    assign req_ready_1_o      = ready_1;
    assign resp_valid_0_o     = resp_valid_0_q;
    assign resp_valid_1_o     = resp_valid_1_q;
    assign resp_rdata_0_o     = resp_rdata_0_q;
    assign resp_rdata_1_o     = resp_rdata_1_q;
    assign mem_read_enable_o  = mem_re_q;
    assign mem_write_enable_o = mem_we_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_write_data_o   = mem_wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: round-robin instance checked through a response
// scoreboard with a reference memory, plus a fixed-priority instance on the same inputs.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clear;
    logic        v0, w0, v1, w1;
    logic [31:0] a0, d0, a1, d1;

    logic        r0, r1, rv0, rv1, m_re, m_we;
    logic [31:0] rd0, rd1, m_addr, m_wdata, m_rdata;
    logic        f_r0, f_r1, f_rv0, f_rv1, f_re, f_we;
    logic [31:0] f_rd0, f_rd1, f_addr, f_wdata, f_rdata;

    logic [31:0] mem_m [1024];
    logic [31:0] mem_f [1024];
    logic [31:0] ref_mem [1024];

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } txn_t;

    txn_t        sb[$];
    int          grant_log[$];
    int          cyc = 0;
    int          serve_cyc = -1;
    logic        serve_wr;
    logic [31:0] serve_addr, serve_wdata;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_0_i(v0), .req_write_0_i(w0), .req_addr_0_i(a0), .req_wdata_0_i(d0),
        .req_valid_1_i(v1), .req_write_1_i(w1), .req_addr_1_i(a1), .req_wdata_1_i(d1),
        .req_ready_0_o(r0), .req_ready_1_o(r1),
        .resp_valid_0_o(rv0), .resp_valid_1_o(rv1),
        .resp_rdata_0_o(rd0), .resp_rdata_1_o(rd1),
        .mem_read_enable_o(m_re), .mem_write_enable_o(m_we),
        .mem_address_o(m_addr), .mem_write_data_o(m_wdata),
        .mem_read_data_i(m_rdata)
    );

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) u_fix (
        .clk_i(clk), .rst_i(rst),
        .req_valid_0_i(v0), .req_write_0_i(w0), .req_addr_0_i(a0), .req_wdata_0_i(d0),
        .req_valid_1_i(v1), .req_write_1_i(w1), .req_addr_1_i(a1), .req_wdata_1_i(d1),
        .req_ready_0_o(f_r0), .req_ready_1_o(f_r1),
        .resp_valid_0_o(f_rv0), .resp_valid_1_o(f_rv1),
        .resp_rdata_0_o(f_rd0), .resp_rdata_1_o(f_rd1),
        .mem_read_enable_o(f_re), .mem_write_enable_o(f_we),
        .mem_address_o(f_addr), .mem_write_data_o(f_wdata),
        .mem_read_data_i(f_rdata)
    );

    // data_memory stand-ins: combinational read, write on the clock edge, 10-bit decode
    assign m_rdata = mem_m[m_addr[9:0]];
    assign f_rdata = mem_f[f_addr[9:0]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) begin
                mem_m[i] <= '0;
                mem_f[i] <= '0;
            end
        end else begin
            if (m_we) mem_m[m_addr[9:0]] <= m_wdata;
            if (f_we) mem_f[f_addr[9:0]] <= f_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic score_resp(input int p, input logic [31:0] got);
        txn_t        e;
        logic [31:0] exp;
        if (sb.size() == 0) begin
            check_eq("resp_unexpected", 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq("resp_port", p, e.port);
            check_eq("resp_latency", cyc, e.due);
            exp = e.wr ? 32'h0 : ref_mem[e.addr[9:0]];
            check_eq("resp_data", got, exp);
            if (e.wr) ref_mem[e.addr[9:0]] = e.wdata;
        end
    endtask

    task automatic note_handshake(input int p, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        txn_t e;
        e.port = p; e.wr = wr; e.addr = addr; e.wdata = wdata; e.due = cyc + 2;
        sb.push_back(e);
        grant_log.push_back(p);
        serve_cyc   = cyc + 1;
        serve_wr    = wr;
        serve_addr  = addr;
        serve_wdata = wr ? wdata : 32'h0;
    endtask

    // Monitor on the falling edge: responses retire before new handshakes are logged.
    initial forever begin
        @(negedge clk);
        if (mem_clear)
            for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        if (rst) begin
            sb.delete();
            serve_cyc = -1;
        end else begin
            check_eq("ready_exclusive", {r0, r1} == 2'b11, 0);
            if (serve_cyc == cyc) begin
                check_eq("serve_we", m_we, serve_wr);
                check_eq("serve_re", m_re, !serve_wr);
                check_eq("serve_addr", m_addr, serve_addr);
                if (serve_wr) check_eq("serve_wdata", m_wdata, serve_wdata);
                serve_cyc = -1;
            end
            if (rv0) score_resp(0, rd0);
            if (rv1) score_resp(1, rd1);
            if (v0 && r0) note_handshake(0, w0, a0, d0);
            if (v1 && r1) note_handshake(1, w1, a1, d1);
        end
    end

    task automatic do_req(input int p, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bit done = 0;
        @(posedge clk); #1;
        if (p == 0) begin v0 = 1; w0 = wr; a0 = addr; d0 = wdata; end
        else        begin v1 = 1; w1 = wr; a1 = addr; d1 = wdata; end
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = (p == 0) ? r0 : r1;
        end
        if (!done) check_eq("req_timeout", 0, 1);
        @(posedge clk); #1;
        if (p == 0) v0 = 0; else v1 = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0;
        int exp_g[5] = '{0, 1, 0, 1, 1};
        bit d0_done, d1_done, hs_seen, dr0, dr1;

        rst = 1; mem_clear = 1;
        v0 = 0; w0 = 0; a0 = 0; d0 = 0;
        v1 = 0; w1 = 0; a1 = 0; d1 = 0;
        repeat (2) @(posedge clk);
        #1 mem_clear = 0;
        @(negedge clk);
        check_eq("reset_ready", {r0, r1}, 2'b00);
        check_eq("reset_resp_valid", {rv0, rv1}, 2'b00);
        check_eq("reset_mem_en", {m_re, m_we}, 2'b00);
        check_eq("reset_mem_addr", m_addr, 0);
        check_eq("reset_rdata", {rd0, rd1}, 64'h0);
        @(posedge clk); #1 rst = 0;

        // seed addresses 1 and 2 identically in both instances
        do_req(0, 1'b1, 32'd1, 32'h1111_0001);
        do_req(0, 1'b1, 32'd2, 32'h2222_0002);
        do_reset();

        // both ports read continuously for 8 cycles; fixed instance watched in parallel
        grant_log.delete();
        @(posedge clk); #1;
        v0 = 1; w0 = 0; a0 = 32'd1;
        v1 = 1; w1 = 0; a1 = 32'd2;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            check_eq("fix_ready0", f_r0, (i < 8) && (i % 2 == 0));
            check_eq("fix_ready1", f_r1, i == 8);
            check_eq("fix_rv_excl", f_rv0 & f_rv1, 0);
            check_eq("fix_en_excl", f_re & f_we, 0);
            @(posedge clk); #1;
            if (i == 7) v0 = 0;
            if (i == 8) v1 = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq("rr_grant_count", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check_eq("rr_grant_order", grant_log[k], exp_g[k]);
        check_eq("fix_rdata0", f_rd0, 32'h1111_0001);
        check_eq("fix_rdata1", f_rd1, 32'h2222_0002);

        // port 0 write then read-back of address 5
        do_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        check_eq("t1_write_rdata", rd0, 32'h0);
        do_req(0, 1'b0, 32'd5, 32'h0);
        check_eq("t1_read_rdata", rd0, 32'hDEAD_BEEF);

        // port 1 writes address 7 while port 0 waits to read it (port 0 served last)
        g0 = grant_log.size();
        @(posedge clk); #1;
        v1 = 1; w1 = 1; a1 = 32'd7; d1 = 32'h1234;
        v0 = 1; w0 = 0; a0 = 32'd7; d0 = 32'h0;
        d0_done = 0; d1_done = 0;
        for (int n = 0; n < 20 && !(d0_done && d1_done); n++) begin
            @(negedge clk);
            dr0 = v0 && r0;
            dr1 = v1 && r1;
            @(posedge clk); #1;
            if (dr0) begin v0 = 0; d0_done = 1; end
            if (dr1) begin v1 = 0; d1_done = 1; end
        end
        check_eq("t4_done", {d0_done, d1_done}, 2'b11);
        repeat (4) @(posedge clk);
        #1;
        check_eq("t4_grant_count", grant_log.size() - g0, 2);
        if (grant_log.size() >= g0 + 2) begin
            check_eq("t4_first_grant", grant_log[g0], 1);
            check_eq("t4_second_grant", grant_log[g0 + 1], 0);
        end
        check_eq("t4_read_rdata", rd0, 32'h1234);

        // reset in the middle of the SERVE cycle of a write to address 3
        @(posedge clk); #1;
        v0 = 1; w0 = 1; a0 = 32'd3; d0 = 32'hAA;
        hs_seen = 0;
        for (int n = 0; n < 20 && !hs_seen; n++) begin
            @(negedge clk);
            hs_seen = r0;
        end
        check_eq("t5_handshake", hs_seen, 1);
        @(posedge clk); #1;
        v0 = 0;
        check_eq("t5_serve_we", m_we, 1);
        #1 rst = 1;
        #1;
        check_eq("t5_rst_en", {m_re, m_we}, 2'b00);
        check_eq("t5_rst_addr", m_addr, 0);
        check_eq("t5_rst_wdata", m_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_eq("t5_no_resp", {rv0, rv1}, 2'b00);
        end
        do_req(0, 1'b0, 32'd3, 32'h0);
        check_eq("t5_read_rdata", rd0, 32'h0);

        // port 0 request withdrawn while port 1 is being served
        g0 = grant_log.size();
        @(posedge clk); #1;
        v1 = 1; w1 = 0; a1 = 32'd7;
        hs_seen = 0;
        for (int n = 0; n < 20 && !hs_seen; n++) begin
            @(negedge clk);
            hs_seen = r1;
        end
        check_eq("t6_p1_handshake", hs_seen, 1);
        @(posedge clk); #1;
        v1 = 0;
        v0 = 1; w0 = 0; a0 = 32'd5;
        @(negedge clk);
        check_eq("t6_ready0_in_serve", r0, 0);
        @(posedge clk); #1;
        v0 = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6_grant_count", grant_log.size() - g0, 1);
        if (grant_log.size() > g0) check_eq("t6_grant_port", grant_log[g0], 1);
        check_eq("t6_p1_rdata", rd1, 32'h1234);

        repeat (3) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
